// File: rtl/relay_gain_sequencer_if.sv
// Relay-control bundle between auto_gain_control and the relay sequencer.
// The master side drives the gain request and raw samples; the slave side reports coil state and blanked data.
interface relay_gain_sequencer_if;
    logic [1:0]  relay_ctrl;
    logic        stable;
    logic [11:0] adc_data;
    logic [3:0]  relay_coil;
    logic [1:0]  gain_code;
    logic        settling;
    logic [11:0] adc_data_out;
    logic        adc_valid;
    logic        gain_locked;
    logic [15:0] switch_count;

    modport master (
        output relay_ctrl, stable, adc_data,
        input  relay_coil, gain_code, settling, adc_data_out, adc_valid, gain_locked, switch_count
    );

    modport slave (
        input  relay_ctrl, stable, adc_data,
        output relay_coil, gain_code, settling, adc_data_out, adc_valid, gain_locked, switch_count
    );
endinterface

// File: rtl/relay_gain_sequencer.sv
// Debounces gain requests, then drives relay coils break-before-make and blanks ADC samples while switching.
// Coil/gain/status update on the edge the FSM changes state; sample path has 1-cycle latency, no backpressure.
module relay_gain_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BREAK_CYCLES    = 50,
    parameter int SETTLE_CYCLES   = 2000,
    parameter int TIMER_W         = 16
) (
    input  logic                    adc_clk,
    input  logic                    rst_n,
    relay_gain_sequencer_if.slave   io_bus
);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_BREAK, S_MAKE} state_t;

    localparam logic [TIMER_W-1:0] DEB_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BRK_LAST = TIMER_W'(BREAK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SET_LAST = TIMER_W'(SETTLE_CYCLES - 1);

    state_t             r_state, w_state_nxt;
    logic [TIMER_W-1:0] r_timer, w_timer_nxt;
    logic [1:0]         r_cand, w_cand_nxt;
    logic [1:0]         r_target, w_target_nxt;
    logic [1:0]         r_gain, w_gain_nxt;
    logic [3:0]         r_coil, w_coil_nxt;
    logic [15:0]        r_count, w_count_nxt;
    logic [11:0]        r_data;
    logic               r_valid;
    logic               r_locked;
    logic               w_settling;

    assign w_settling = (r_state == S_BREAK) || (r_state == S_MAKE);

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer + 1'b1;
        w_cand_nxt   = r_cand;
        w_target_nxt = r_target;
        w_gain_nxt   = r_gain;
        w_count_nxt  = r_count;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (io_bus.relay_ctrl != r_gain) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt  = S_BREAK;
                        w_target_nxt = io_bus.relay_ctrl;
                    end else begin
                        w_state_nxt = S_DEBOUNCE;
                        w_cand_nxt  = io_bus.relay_ctrl;
                        w_timer_nxt = TIMER_W'(1);
                    end
                end
            end
            S_DEBOUNCE: begin
                // A different new request restarts the hold count rather than aborting.
                if (io_bus.relay_ctrl == r_gain) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else if (io_bus.relay_ctrl != r_cand) begin
                    w_cand_nxt  = io_bus.relay_ctrl;
                    w_timer_nxt = TIMER_W'(1);
                end else if (r_timer == DEB_LAST) begin
                    w_state_nxt  = S_BREAK;
                    w_target_nxt = r_cand;
                    w_timer_nxt  = '0;
                end
            end
            S_BREAK: begin
                if (r_timer == BRK_LAST) begin
                    w_state_nxt = S_MAKE;
                    w_timer_nxt = '0;
                    w_gain_nxt  = r_target;
                    w_count_nxt = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
                end
            end
            default: begin
                if (r_timer == SET_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end
            end
        endcase
        // Coil drive is registered from the next state so it never glitches through two coils.
        w_coil_nxt = (w_state_nxt == S_BREAK) ? 4'b0000 : (4'b0001 << w_gain_nxt);
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            r_state  <= S_MAKE;
            r_timer  <= '0;
            r_cand   <= 2'd0;
            r_target <= 2'd0;
            r_gain   <= 2'd0;
            r_coil   <= 4'b0001;
            r_count  <= 16'd0;
            r_data   <= 12'd0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_cand   <= w_cand_nxt;
            r_target <= w_target_nxt;
            r_gain   <= w_gain_nxt;
            r_coil   <= w_coil_nxt;
            r_count  <= w_count_nxt;
            if (!w_settling) begin
                r_data  <= io_bus.adc_data;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
            r_locked <= io_bus.stable && (w_state_nxt == S_IDLE);
        end
    end

    assign io_bus.relay_coil   = r_coil;
    assign io_bus.gain_code    = r_gain;
    assign io_bus.settling     = w_settling;
    assign io_bus.adc_data_out = r_data;
    assign io_bus.adc_valid    = r_valid;
    assign io_bus.gain_locked  = r_locked;
    assign io_bus.switch_count = r_count;

endmodule

// File: tb/tb_relay_gain_sequencer.sv
// Bench for relay_gain_sequencer with DEBOUNCE=4, BREAK=3, SETTLE=10.
// Status-change events are queued by the stimulus and popped by a negedge monitor.
module tb_relay_gain_sequencer;

    typedef struct {
        logic [3:0]  coil;
        logic [1:0]  gain;
        logic [15:0] cnt;
        logic        set;
        logic        lock;
        int          dt;
    } exp_t;

    logic adc_clk = 1'b0;
    logic rst_n;
    logic rst_q = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t_mark = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t e;

    logic [3:0]  p_coil;
    logic [1:0]  p_gain;
    logic [15:0] p_cnt;
    logic        p_set;
    logic        p_lock;
    logic [11:0] last_data = 12'd0;

    relay_gain_sequencer_if bus();

    relay_gain_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .BREAK_CYCLES   (3),
        .SETTLE_CYCLES  (10),
        .TIMER_W        (16)
    ) dut (
        .adc_clk(adc_clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 adc_clk = ~adc_clk;

    always @(posedge adc_clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge adc_clk);
            bus.adc_data = 12'(cyc + 100);
        end
    endtask

    task automatic push(input logic [3:0] coil, input logic [1:0] gain, input logic [15:0] cnt,
                        input logic set, input logic lock, input int dt);
        exp_t x;
        x.coil = coil; x.gain = gain; x.cnt = cnt; x.set = set; x.lock = lock; x.dt = dt;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: status events against the queue, sample path against the ramp model.
    always @(negedge adc_clk) begin
        if (!mon_en) begin
            p_coil = bus.relay_coil; p_gain = bus.gain_code; p_cnt = bus.switch_count;
            p_set = bus.settling;    p_lock = bus.gain_locked;
        end else begin
            if (bus.relay_coil != p_coil || bus.gain_code != p_gain || bus.switch_count != p_cnt ||
                bus.settling != p_set || bus.gain_locked != p_lock) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: coil=%b gain=%0d cnt=%0d set=%b lock=%b dt=%0d",
                             bus.relay_coil, bus.gain_code, bus.switch_count, bus.settling,
                             bus.gain_locked, cyc - t_mark);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.relay_coil != e.coil || bus.gain_code != e.gain || bus.switch_count != e.cnt ||
                        bus.settling != e.set || bus.gain_locked != e.lock || (cyc - t_mark) != e.dt) begin
                        failures++;
                        $display("FAIL event: got coil=%b gain=%0d cnt=%0d set=%b lock=%b dt=%0d expected coil=%b gain=%0d cnt=%0d set=%b lock=%b dt=%0d",
                                 bus.relay_coil, bus.gain_code, bus.switch_count, bus.settling,
                                 bus.gain_locked, cyc - t_mark, e.coil, e.gain, e.cnt, e.set, e.lock, e.dt);
                    end
                end
                p_coil = bus.relay_coil; p_gain = bus.gain_code; p_cnt = bus.switch_count;
                p_set = bus.settling;    p_lock = bus.gain_locked;
            end
            checks++;
            if (!rst_q) begin
                last_data = 12'd0;
                if (bus.adc_data_out != 12'd0 || bus.adc_valid != 1'b0) begin
                    failures++;
                    $display("FAIL data_reset: got data=%0d valid=%b expected 0/0", bus.adc_data_out, bus.adc_valid);
                end
            end else if (bus.adc_valid) begin
                if (bus.adc_data_out != 12'(cyc + 99)) begin
                    failures++;
                    $display("FAIL data_valid: got %0d expected %0d", bus.adc_data_out, 12'(cyc + 99));
                end
                last_data = 12'(cyc + 99);
            end else if (bus.adc_data_out != last_data) begin
                failures++;
                $display("FAIL data_hold: got %0d expected %0d", bus.adc_data_out, last_data);
            end
        end
    end

    initial begin
        int c;
        rst_n = 1'b0;
        bus.relay_ctrl = 2'd0;
        bus.stable = 1'b1;
        bus.adc_data = 12'd0;

        // 1: reset held for two edges, then power-up settle of gain 0
        step(2);
        chk("rst_coil", bus.relay_coil, 4'b0001);
        chk("rst_gain", bus.gain_code, 0);
        chk("rst_settling", bus.settling, 1);
        chk("rst_count", bus.switch_count, 0);
        chk("rst_valid", bus.adc_valid, 0);
        chk("rst_data", bus.adc_data_out, 0);
        chk("rst_locked", bus.gain_locked, 0);
        rst_n = 1'b1;
        t_mark = cyc;
        push(4'b0001, 2'd0, 16'd0, 1'b0, 1'b1, 10);
        mon_en = 1'b1;
        step(10);
        chk("pwrup_valid_low", bus.adc_valid, 0);
        step(1);
        chk("pwrup_valid_high", bus.adc_valid, 1);
        step(2);

        // 2: switch 0 -> 2
        t_mark = cyc;
        push(4'b0001, 2'd0, 16'd0, 1'b0, 1'b0, 1);
        push(4'b0000, 2'd0, 16'd0, 1'b1, 1'b0, 4);
        push(4'b0100, 2'd2, 16'd1, 1'b1, 1'b0, 7);
        push(4'b0100, 2'd2, 16'd1, 1'b0, 1'b1, 17);
        bus.relay_ctrl = 2'd2;
        step(20);

        // 3: glitch of 3 cycles is rejected
        t_mark = cyc;
        push(4'b0100, 2'd2, 16'd1, 1'b0, 1'b0, 1);
        push(4'b0100, 2'd2, 16'd1, 1'b0, 1'b1, 4);
        bus.relay_ctrl = 2'd1;
        step(3);
        bus.relay_ctrl = 2'd2;
        step(10);

        // 4: retarget in debounce: 1,1,3,3,3,3
        t_mark = cyc;
        push(4'b0100, 2'd2, 16'd1, 1'b0, 1'b0, 1);
        push(4'b0000, 2'd2, 16'd1, 1'b1, 1'b0, 6);
        push(4'b1000, 2'd3, 16'd2, 1'b1, 1'b0, 9);
        push(4'b1000, 2'd3, 16'd2, 1'b0, 1'b1, 19);
        bus.relay_ctrl = 2'd1;
        step(2);
        bus.relay_ctrl = 2'd3;
        step(22);

        // 5: request change during MAKE is deferred until after settle
        t_mark = cyc;
        push(4'b1000, 2'd3, 16'd2, 1'b0, 1'b0, 1);
        push(4'b0000, 2'd3, 16'd2, 1'b1, 1'b0, 4);
        push(4'b0010, 2'd1, 16'd3, 1'b1, 1'b0, 7);
        push(4'b0010, 2'd1, 16'd3, 1'b0, 1'b1, 17);
        push(4'b0010, 2'd1, 16'd3, 1'b0, 1'b0, 18);
        push(4'b0000, 2'd1, 16'd3, 1'b1, 1'b0, 21);
        push(4'b0100, 2'd2, 16'd4, 1'b1, 1'b0, 24);
        push(4'b0100, 2'd2, 16'd4, 1'b0, 1'b1, 34);
        bus.relay_ctrl = 2'd1;
        step(11);
        bus.relay_ctrl = 2'd2;
        step(28);

        // 6: blanking during switch, then reset mid-MAKE
        c = cyc;
        t_mark = cyc;
        push(4'b0100, 2'd2, 16'd4, 1'b0, 1'b0, 1);
        push(4'b0000, 2'd2, 16'd4, 1'b1, 1'b0, 4);
        push(4'b0001, 2'd0, 16'd5, 1'b1, 1'b0, 7);
        push(4'b0001, 2'd0, 16'd0, 1'b1, 1'b0, 11);
        bus.relay_ctrl = 2'd0;
        step(4);
        chk("blank_last_sample", bus.adc_data_out, 12'(c + 103));
        chk("blank_last_valid", bus.adc_valid, 1);
        step(1);
        chk("blank_hold_break", bus.adc_data_out, 12'(c + 103));
        chk("blank_valid_break", bus.adc_valid, 0);
        step(5);
        chk("blank_hold_make", bus.adc_data_out, 12'(c + 103));
        chk("blank_valid_make", bus.adc_valid, 0);
        rst_n = 1'b0;
        step(1);
        chk("midrst_data", bus.adc_data_out, 0);
        chk("midrst_coil", bus.relay_coil, 4'b0001);
        step(1);
        rst_n = 1'b1;
        t_mark = cyc;
        push(4'b0001, 2'd0, 16'd0, 1'b0, 1'b1, 10);
        step(12);

        // 7: lock follows the AGC stable flag while idle
        t_mark = cyc;
        push(4'b0001, 2'd0, 16'd0, 1'b0, 1'b0, 1);
        push(4'b0001, 2'd0, 16'd0, 1'b0, 1'b1, 4);
        bus.stable = 1'b0;
        step(3);
        bus.stable = 1'b1;
        step(5);

        chk("events_left", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
